// File: rtl/router_fifo.sv
// Router output-port FIFO: 16 x 9-bit storage (bit 8 marks the header byte), with a packet byte counter.
// Optional macro ROUTER_FIFO_OCC_EN adds the fifo_count occupancy output.
module router_fifo (
   input  logic       clock,
   input  logic       reset,
   input  logic       soft_reset,
   input  logic       write_enb,
   input  logic       read_enb,
   input  logic       lfd_state,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       full,
   output logic       empty
`ifdef ROUTER_FIFO_OCC_EN
   ,
   output logic [4:0] fifo_count
`endif
);

   logic [8:0] mem [16];
   logic [4:0] wr_ptr;
   logic [4:0] rd_ptr;
   logic [5:0] pkt_cnt;
   logic       do_wr;
   logic       do_rd;
   logic       any_reset;
   logic [8:0] rd_word;

   always_comb begin
      empty     = (wr_ptr == rd_ptr);
      full      = (wr_ptr[3:0] == rd_ptr[3:0]) && (wr_ptr[4] != rd_ptr[4]);
      do_wr     = write_enb && !full;
      do_rd     = read_enb && !empty;
      any_reset = reset || soft_reset;
      rd_word   = mem[rd_ptr[3:0]];
   end

`ifdef ROUTER_FIFO_OCC_EN
   always_comb fifo_count = wr_ptr - rd_ptr;
`endif

   // Storage is never cleared; a reset only suppresses the write in that cycle.
   always_ff @(posedge clock) begin
      if (!any_reset && do_wr)
         mem[wr_ptr[3:0]] <= {lfd_state, data_in};
   end

   always_ff @(posedge clock) begin
      if (any_reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pkt_cnt  <= '0;
         data_out <= '0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + 5'd1;
         if (do_rd) begin
            rd_ptr   <= rd_ptr + 5'd1;
            data_out <= rd_word[7:0];
            // Header loads payload length plus one parity byte.
            if (rd_word[8])
               pkt_cnt <= rd_word[7:2] + 6'd1;
            else if (pkt_cnt != 6'd0)
               pkt_cnt <= pkt_cnt - 6'd1;
         end else if (pkt_cnt == 6'd0) begin
            data_out <= '0;
         end
      end
   end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 The module SHALL have a single clock and a reset that is synchronous and active-high.
REQ-002 Port clock  input  1  rising-edge clock for all state.
REQ-003 Port reset  input  1  synchronous active-high reset.
REQ-004 Port soft_reset  input  1  per-port soft reset from router_sync; synchronous, active-high.
REQ-005 Port write_enb  input  1  write strobe; this port's bit of router_sync write_enb[2:0].
REQ-006 Port read_enb  input  1  read strobe from the output-port consumer.
REQ-007 Port lfd_state  input  1  marks data_in as the packet header byte.
REQ-008 Port data_in  input  8  byte to store; a header byte holds payload length in [7:2] and destination in [1:0].
REQ-009 Port data_out  output  8  registered read data.
REQ-010 Port full  output  1  combinational; goes to router_sync full_N.
REQ-011 Port empty  output  1  combinational; goes to router_sync empty_N.

Function
REQ-012 Storage SHALL be 16 entries x 9 bits; bit 8 = lfd_state captured with the byte.
REQ-013 Write and read pointers SHALL be 5 bits: [3:0] is the index and [4] is the wrap bit.
REQ-014 Pointer increment SHALL wrap modulo 32, so the index wraps modulo 16.
REQ-015 empty SHALL be 1 when wr_ptr == rd_ptr.
REQ-016 full SHALL be 1 when the pointer indices are equal and the wrap bits differ.
REQ-017 A write SHALL occur when write_enb=1 and full=0: mem[wr_ptr[3:0]] <= {lfd_state, data_in}, and wr_ptr increments.
REQ-018 write_enb while full SHALL be ignored: no pointer change, no overwrite.
REQ-019 A read SHALL occur when read_enb=1 and empty=0: data_out <= mem[rd_ptr[3:0]][7:0] on the same edge, and rd_ptr increments; read latency is 1 clock.
REQ-020 read_enb while empty SHALL NOT move rd_ptr.
REQ-021 While empty with read_enb, data_out SHALL hold its value, except as stated in REQ-024.
REQ-022 A 6-bit packet counter SHALL load mem[rd][7:2]+1 (payload plus parity) when a read entry has bit 8 = 1.
REQ-023 On each read of an entry with bit 8 = 0 and counter > 0, the packet counter SHALL decrement by 1.
REQ-024 When the counter is 0 and no read occurs in a cycle, data_out SHALL be driven to 8'h00 on that edge.
REQ-025 A header with payload length 0 SHALL load counter = 1.
REQ-026 Simultaneous read and write while full: the read SHALL proceed and the write SHALL be dropped, because full is evaluated before the edge.
REQ-027 Simultaneous read and write while empty: the write SHALL proceed and the read SHALL be blocked.
REQ-028 Otherwise, simultaneous read and write SHALL both complete, and occupancy SHALL be unchanged.

Reset
REQ-029 reset SHALL set wr_ptr=0, rd_ptr=0, counter=0 and data_out=8'h00, giving full=0 and empty=1.
REQ-030 soft_reset SHALL have the same effect as reset on the pointers, counter and data_out.
REQ-031 reset SHALL take priority over soft_reset.
REQ-032 soft_reset SHALL take priority over reads and writes in the same cycle.
REQ-033 Memory contents SHALL NOT be cleared by either reset.
REQ-034 A reset or soft_reset asserted mid-packet SHALL discard all queued bytes.
REQ-035 The first write after reset is released SHALL land in entry 0.

Configuration
REQ-036 Macro ROUTER_FIFO_OCC_EN SHALL, when defined, add output fifo_count[4:0] = wr_ptr - rd_ptr (mod 32), range 0..16.
REQ-037 fifo_count SHALL be 0 under reset and soft_reset.
REQ-038 When ROUTER_FIFO_OCC_EN is undefined, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039 Reset, then write a header 8'h0D (len 3, addr 01) with lfd_state=1, then 8'hA1, 8'hA2, 8'hA3 and parity 8'h55. Required: empty=0 after the first write, and 5 entries stored.
REQ-040 Then read 5 cycles. Required: data_out sequence 0D, A1, A2, A3, 55, one clock after each read_enb; empty=1 after the fifth read; data_out=00 the next idle cycle.
REQ-041 Write 16 bytes without reading. Required: full=1 after the 16th. A 17th write of 8'hFF is dropped, and reading all 16 returns the original bytes in order with no FF.
REQ-042 While full=1, assert read_enb and write_enb with 8'h77. Required: one byte is read, full=0 afterwards, and 8'h77 is not stored.
REQ-043 Write 3 bytes, then pulse soft_reset with write_enb=1. Required: empty=1 and full=0 the next cycle, data_out=00, and nothing written that cycle. (With ROUTER_FIFO_OCC_EN, fifo_count=0.)
REQ-044 Write 20 bytes, interleaving a read every cycle after the 4th write. Required: pointer wrap past index 15 is correct, read order matches write order, and full is never asserted.
